// File: rtl/boc_corr_accum.sv
// rtl/boc_corr_accum.sv - BOC code wipe-off and per-code-period I/Q accumulate-and-dump.
// Optional sample-count output enabled by defining BOC_CORR_SAMPLE_CNT_EN.
module boc_corr_accum #(
  parameter int SAMPLE_WIDTH = 4,
  parameter int ACC_WIDTH    = 20,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                           rx_clk,
  input  logic                           rx_rst,
  input  logic signed [SAMPLE_WIDTH-1:0] rx_sample_i,
  input  logic signed [SAMPLE_WIDTH-1:0] rx_sample_q,
  input  logic                           rx_sample_vld,
  input  logic                           rx_loc_boc,
  input  logic                           rx_prn_sop,
  input  logic                           rx_prn_eop,
  output logic signed [ACC_WIDTH-1:0]    tx_acc_i,
  output logic signed [ACC_WIDTH-1:0]    tx_acc_q,
  output logic                           tx_acc_vld,
  output logic                           tx_acc_ovf,
  output logic                           tx_resync,
`ifdef BOC_CORR_SAMPLE_CNT_EN
  output logic [CNT_WIDTH-1:0]           tx_samp_cnt,
`endif
  output logic [CNT_WIDTH-1:0]           tx_epoch_cnt
);

  localparam int PW = SAMPLE_WIDTH + 1;

  typedef enum logic {IDLE, ACCUM} state_t;

  // Returns {clamped, saturated sum}.
  function automatic logic [ACC_WIDTH:0] sat_add(input logic signed [ACC_WIDTH-1:0] a,
                                                 input logic signed [PW-1:0] b);
    logic signed [ACC_WIDTH:0] s;
    s = (ACC_WIDTH+1)'(a) + (ACC_WIDTH+1)'(b);
    if (s[ACC_WIDTH] != s[ACC_WIDTH-1])
      sat_add = {1'b1, s[ACC_WIDTH], {(ACC_WIDTH-1){~s[ACC_WIDTH]}}};
    else
      sat_add = {1'b0, s[ACC_WIDTH-1:0]};
  endfunction

  logic signed [PW-1:0] samp_i_x, samp_q_x;
  logic signed [PW-1:0] s1_prod_i_q, s1_prod_q_q;
  logic                 s1_vld_q, s1_sop_q, s1_eop_q;

  assign samp_i_x = {rx_sample_i[SAMPLE_WIDTH-1], rx_sample_i};
  assign samp_q_x = {rx_sample_q[SAMPLE_WIDTH-1], rx_sample_q};

  always_ff @(posedge rx_clk) begin
    if (rx_rst) begin
      s1_vld_q    <= 1'b0;
      s1_sop_q    <= 1'b0;
      s1_eop_q    <= 1'b0;
      s1_prod_i_q <= '0;
      s1_prod_q_q <= '0;
    end else begin
      s1_vld_q <= rx_sample_vld;
      if (rx_sample_vld) begin
        s1_prod_i_q <= rx_loc_boc ? -samp_i_x : samp_i_x;
        s1_prod_q_q <= rx_loc_boc ? -samp_q_x : samp_q_x;
        s1_sop_q    <= rx_prn_sop;
        s1_eop_q    <= rx_prn_eop;
      end
    end
  end

  state_t                       state_q, state_d;
  logic signed [ACC_WIDTH-1:0]  acc_i_q, acc_i_d, acc_q_q, acc_q_d;
  logic                         ovf_q, ovf_d, dump_q, dump_d, resync_q, resync_d;
  logic [ACC_WIDTH:0]           sum_i, sum_q;
`ifdef BOC_CORR_SAMPLE_CNT_EN
  logic [CNT_WIDTH-1:0]         cnt_q, cnt_d;
`endif

  assign sum_i = sat_add(acc_i_q, s1_prod_i_q);
  assign sum_q = sat_add(acc_q_q, s1_prod_q_q);

  always_comb begin
    state_d  = state_q;
    acc_i_d  = acc_i_q;
    acc_q_d  = acc_q_q;
    ovf_d    = ovf_q;
    dump_d   = 1'b0;
    resync_d = 1'b0;
`ifdef BOC_CORR_SAMPLE_CNT_EN
    cnt_d    = cnt_q;
`endif
    if (s1_vld_q) begin
      if (s1_sop_q) begin
        // A period start always reloads, whether from IDLE or as a mid-period resync.
        resync_d = (state_q == ACCUM);
        acc_i_d  = ACC_WIDTH'(s1_prod_i_q);
        acc_q_d  = ACC_WIDTH'(s1_prod_q_q);
        ovf_d    = 1'b0;
`ifdef BOC_CORR_SAMPLE_CNT_EN
        cnt_d    = CNT_WIDTH'(1);
`endif
        dump_d   = s1_eop_q;
        state_d  = s1_eop_q ? IDLE : ACCUM;
      end else if (state_q == ACCUM) begin
        acc_i_d = sum_i[ACC_WIDTH-1:0];
        acc_q_d = sum_q[ACC_WIDTH-1:0];
        ovf_d   = ovf_q | sum_i[ACC_WIDTH] | sum_q[ACC_WIDTH];
`ifdef BOC_CORR_SAMPLE_CNT_EN
        cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
`endif
        dump_d  = s1_eop_q;
        state_d = s1_eop_q ? IDLE : ACCUM;
      end
    end
  end

  always_ff @(posedge rx_clk) begin
    if (rx_rst) begin
      state_q  <= IDLE;
      acc_i_q  <= '0;
      acc_q_q  <= '0;
      ovf_q    <= 1'b0;
      dump_q   <= 1'b0;
      resync_q <= 1'b0;
`ifdef BOC_CORR_SAMPLE_CNT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      acc_i_q  <= acc_i_d;
      acc_q_q  <= acc_q_d;
      ovf_q    <= ovf_d;
      dump_q   <= dump_d;
      resync_q <= resync_d;
`ifdef BOC_CORR_SAMPLE_CNT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign tx_resync = resync_q;

  // The dumped sum sits in acc_q for one cycle; capture it before a following sop reloads.
  always_ff @(posedge rx_clk) begin
    if (rx_rst) begin
      tx_acc_i     <= '0;
      tx_acc_q     <= '0;
      tx_acc_ovf   <= 1'b0;
      tx_acc_vld   <= 1'b0;
      tx_epoch_cnt <= '0;
`ifdef BOC_CORR_SAMPLE_CNT_EN
      tx_samp_cnt  <= '0;
`endif
    end else begin
      tx_acc_vld <= dump_q;
      if (dump_q) begin
        tx_acc_i     <= acc_i_q;
        tx_acc_q     <= acc_q_q;
        tx_acc_ovf   <= ovf_q;
        tx_epoch_cnt <= tx_epoch_cnt + 1'b1;
`ifdef BOC_CORR_SAMPLE_CNT_EN
        tx_samp_cnt  <= cnt_q;
`endif
      end
    end
  end

endmodule

// File: tb/tb_boc_corr_accum.sv
// tb/tb_boc_corr_accum.sv - directed self-checking bench for boc_corr_accum.
// Checks tx_samp_cnt too when BOC_CORR_SAMPLE_CNT_EN is defined.
module tb_boc_corr_accum;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic signed [3:0] si = '0, sq = '0;
  logic              vld = 1'b0, boc = 1'b0, sop = 1'b0, eop = 1'b0;

  logic signed [19:0] acc_i, acc_q;
  logic               acc_vld, acc_ovf, resync;
  logic [15:0]        epoch;
  logic signed [7:0]  acc8_i, acc8_q;
  logic               acc8_vld, acc8_ovf, resync8;
  logic [15:0]        epoch8;
`ifdef BOC_CORR_SAMPLE_CNT_EN
  logic [15:0]        samp_cnt, samp_cnt8;
`endif

  always #5 clk = ~clk;

  boc_corr_accum #(.SAMPLE_WIDTH(4), .ACC_WIDTH(20), .CNT_WIDTH(16)) dut (
    .rx_clk(clk), .rx_rst(rst), .rx_sample_i(si), .rx_sample_q(sq),
    .rx_sample_vld(vld), .rx_loc_boc(boc), .rx_prn_sop(sop), .rx_prn_eop(eop),
    .tx_acc_i(acc_i), .tx_acc_q(acc_q), .tx_acc_vld(acc_vld), .tx_acc_ovf(acc_ovf),
    .tx_resync(resync),
`ifdef BOC_CORR_SAMPLE_CNT_EN
    .tx_samp_cnt(samp_cnt),
`endif
    .tx_epoch_cnt(epoch));

  boc_corr_accum #(.SAMPLE_WIDTH(4), .ACC_WIDTH(8), .CNT_WIDTH(16)) dut8 (
    .rx_clk(clk), .rx_rst(rst), .rx_sample_i(si), .rx_sample_q(sq),
    .rx_sample_vld(vld), .rx_loc_boc(boc), .rx_prn_sop(sop), .rx_prn_eop(eop),
    .tx_acc_i(acc8_i), .tx_acc_q(acc8_q), .tx_acc_vld(acc8_vld), .tx_acc_ovf(acc8_ovf),
    .tx_resync(resync8),
`ifdef BOC_CORR_SAMPLE_CNT_EN
    .tx_samp_cnt(samp_cnt8),
`endif
    .tx_epoch_cnt(epoch8));

  typedef struct {
    int   i;
    int   q;
    logic ovf;
    int   ep;
    int   sc;
    int   cyc;
  } dump_t;

  dump_t dq[$];
  dump_t dq8[$];
  int    cyc = 0;
  int    eop_edge = 0;
  int    n_resync = 0;
  int    n_tests = 0;
  int    n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    dump_t d;
    if (resync) n_resync++;
    if (acc_vld) begin
      d.i = int'(acc_i); d.q = int'(acc_q); d.ovf = acc_ovf; d.ep = int'(epoch); d.cyc = cyc;
`ifdef BOC_CORR_SAMPLE_CNT_EN
      d.sc = int'(samp_cnt);
`else
      d.sc = 0;
`endif
      dq.push_back(d);
    end
    if (acc8_vld) begin
      d.i = int'(acc8_i); d.q = int'(acc8_q); d.ovf = acc8_ovf; d.ep = int'(epoch8); d.cyc = cyc;
      d.sc = 0;
      dq8.push_back(d);
    end
  end

  task automatic send(input logic v, input logic signed [3:0] vi, vq,
                      input logic b, s, e);
    @(negedge clk);
    vld = v; si = vi; sq = vq; boc = b; sop = s; eop = e;
    if (v && e) eop_edge = cyc + 1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) send(1'b0, 4'sd0, 4'sd0, 1'b0, 1'b0, 1'b0);
  endtask

  // mode 0: chip 0 throughout, 1: alternate 0/1, 2: chip 1 throughout
  task automatic send_period(input int n, input logic signed [3:0] vi, vq, input int mode);
    for (int k = 0; k < n; k++)
      send(1'b1, vi, vq, (mode == 2) ? 1'b1 : (mode == 1) ? k[0] : 1'b0, k == 0, k == n - 1);
    idle(1);
  endtask

  task automatic wait_dump(input int n);
    for (int k = 0; k < 40 && dq.size() < n; k++) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; vld = 1'b0; sop = 1'b0; eop = 1'b0; boc = 1'b0; si = '0; sq = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    dq.delete(); dq8.delete(); n_resync = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({acc_i, acc_q, acc_vld, acc_ovf, resync, epoch} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got i=%0d q=%0d vld=%b ovf=%b rs=%b ep=%0d, want all 0",
               acc_i, acc_q, acc_vld, acc_ovf, resync, epoch);
    end
  endtask

  task automatic test_basic();
    send_period(10, 4'sd3, -4'sd2, 0);
    wait_dump(1);
    idle(3);
    n_tests++;
    if (dq.size() != 1) begin
      n_fail++; $display("FAIL basic_count: got %0d dumps, want 1", dq.size());
    end else begin
      n_tests++;
      if (dq[0].i != 30 || dq[0].q != -20 || dq[0].ovf !== 1'b0 || dq[0].ep != 1) begin
        n_fail++;
        $display("FAIL basic_data: got i=%0d q=%0d ovf=%b ep=%0d, want 30 -20 0 1",
                 dq[0].i, dq[0].q, dq[0].ovf, dq[0].ep);
      end
      n_tests++;
      if (dq[0].cyc != eop_edge + 2) begin
        n_fail++; $display("FAIL basic_latency: got edge %0d, want %0d", dq[0].cyc, eop_edge + 2);
      end
`ifdef BOC_CORR_SAMPLE_CNT_EN
      n_tests++;
      if (dq[0].sc != 10) begin
        n_fail++; $display("FAIL basic_sampcnt: got %0d, want 10", dq[0].sc);
      end
`endif
    end
    n_tests++;
    if (acc_i !== 20'sd30 || acc_vld !== 1'b0) begin
      n_fail++; $display("FAIL basic_hold: got i=%0d vld=%b, want 30 0", acc_i, acc_vld);
    end
    dq.delete();
  endtask

  task automatic test_boc_wipe();
    send_period(10, 4'sd3, 4'sd1, 1);
    wait_dump(1);
    n_tests++;
    if (dq.size() != 1 || dq[0].i != 0 || dq[0].q != 0 || dq[0].ep != 2) begin
      n_fail++; $display("FAIL boc_alt: got n=%0d i=%0d q=%0d ep=%0d, want 1 0 0 2",
                         dq.size(), dq.size() ? dq[0].i : 0, dq.size() ? dq[0].q : 0,
                         dq.size() ? dq[0].ep : 0);
    end
    dq.delete();
    send_period(10, -4'sd8, 4'sd7, 2);
    wait_dump(1);
    n_tests++;
    if (dq.size() != 1 || dq[0].i != 80 || dq[0].q != -70 || dq[0].ovf !== 1'b0 || dq[0].ep != 3) begin
      n_fail++; $display("FAIL boc_neg8: got n=%0d i=%0d q=%0d ovf=%b, want 1 80 -70 0",
                         dq.size(), dq.size() ? dq[0].i : 0, dq.size() ? dq[0].q : 0,
                         dq.size() ? dq[0].ovf : 1'b0);
    end
    dq.delete();
  endtask

  task automatic test_saturation();
    dq8.delete();
    send_period(20, 4'sd7, -4'sd8, 0);
    wait_dump(1);
    idle(1);
    n_tests++;
    if (dq8.size() != 1 || dq8[0].i != 127 || dq8[0].q != -128 || dq8[0].ovf !== 1'b1) begin
      n_fail++; $display("FAIL sat8_clamp: got n=%0d i=%0d q=%0d ovf=%b, want 1 127 -128 1",
                         dq8.size(), dq8.size() ? dq8[0].i : 0, dq8.size() ? dq8[0].q : 0,
                         dq8.size() ? dq8[0].ovf : 1'b0);
    end
    n_tests++;
    if (dq.size() != 1 || dq[0].i != 140 || dq[0].q != -160 || dq[0].ovf !== 1'b0 || dq[0].ep != 4) begin
      n_fail++; $display("FAIL sat20_wide: got n=%0d i=%0d q=%0d ovf=%b, want 1 140 -160 0",
                         dq.size(), dq.size() ? dq[0].i : 0, dq.size() ? dq[0].q : 0,
                         dq.size() ? dq[0].ovf : 1'b0);
    end
    dq.delete(); dq8.delete();
    send_period(5, 4'sd1, 4'sd0, 0);
    wait_dump(1);
    idle(1);
    n_tests++;
    if (dq8.size() != 1 || dq8[0].i != 5 || dq8[0].ovf !== 1'b0) begin
      n_fail++; $display("FAIL sat8_recover: got n=%0d i=%0d ovf=%b, want 1 5 0",
                         dq8.size(), dq8.size() ? dq8[0].i : 0, dq8.size() ? dq8[0].ovf : 1'b1);
    end
    dq.delete(); dq8.delete();
  endtask

  task automatic test_resync();
    n_resync = 0;
    for (int k = 0; k < 4; k++) send(1'b1, 4'sd2, 4'sd1, 1'b0, k == 0, 1'b0);
    for (int k = 0; k < 4; k++) send(1'b1, 4'sd2, 4'sd1, 1'b0, k == 0, k == 3);
    idle(1);
    wait_dump(1);
    n_tests++;
    if (n_resync != 1) begin
      n_fail++; $display("FAIL resync_pulse: got %0d pulses, want 1", n_resync);
    end
    n_tests++;
    if (dq.size() != 1 || dq[0].i != 8 || dq[0].q != 4 || dq[0].ep != 6) begin
      n_fail++; $display("FAIL resync_data: got n=%0d i=%0d q=%0d, want 1 8 4",
                         dq.size(), dq.size() ? dq[0].i : 0, dq.size() ? dq[0].q : 0);
    end
`ifdef BOC_CORR_SAMPLE_CNT_EN
    n_tests++;
    if (dq.size() != 1 || dq[0].sc != 4) begin
      n_fail++; $display("FAIL resync_sampcnt: got %0d, want 4", dq.size() ? dq[0].sc : -1);
    end
`endif
    dq.delete();
  endtask

  task automatic test_idle_eop();
    do_reset();
    send(1'b1, 4'sd4, 4'sd4, 1'b0, 1'b0, 1'b1);
    idle(6);
    n_tests++;
    if (dq.size() != 0 || epoch !== 16'd0) begin
      n_fail++; $display("FAIL idle_eop: got %0d dumps ep=%0d, want 0 0", dq.size(), epoch);
    end
    send(1'b1, -4'sd5, 4'sd3, 1'b0, 1'b1, 1'b1);
    idle(1);
    wait_dump(1);
    n_tests++;
    if (dq.size() != 1 || dq[0].i != -5 || dq[0].q != 3 || dq[0].ep != 1 || dq[0].cyc != eop_edge + 2) begin
      n_fail++; $display("FAIL single_sample: got n=%0d i=%0d q=%0d ep=%0d, want 1 -5 3 1",
                         dq.size(), dq.size() ? dq[0].i : 0, dq.size() ? dq[0].q : 0,
                         dq.size() ? dq[0].ep : 0);
    end
    dq.delete();
  endtask

  task automatic test_back_to_back();
    int lens[3] = '{6, 7, 5};
    int exp_i[3];
    int exp_q[3];
    logic signed [3:0] vi, vq;
    logic b;
    do_reset();
    for (int p = 0; p < 3; p++) begin
      exp_i[p] = 0; exp_q[p] = 0;
      for (int k = 0; k < lens[p]; k++) begin
        while ($urandom_range(0, 2) == 0)
          send(1'b0, 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        vi = 4'($urandom); vq = 4'($urandom); b = 1'($urandom);
        exp_i[p] += b ? -int'(vi) : int'(vi);
        exp_q[p] += b ? -int'(vq) : int'(vq);
        send(1'b1, vi, vq, b, k == 0, k == lens[p] - 1);
      end
    end
    idle(1);
    wait_dump(3);
    n_tests++;
    if (dq.size() != 3) begin
      n_fail++; $display("FAIL b2b_count: got %0d dumps, want 3", dq.size());
    end else begin
      for (int p = 0; p < 3; p++) begin
        n_tests++;
        if (dq[p].i != exp_i[p] || dq[p].q != exp_q[p] || dq[p].ep != p + 1) begin
          n_fail++; $display("FAIL b2b_epoch%0d: got i=%0d q=%0d ep=%0d, want %0d %0d %0d",
                             p, dq[p].i, dq[p].q, dq[p].ep, exp_i[p], exp_q[p], p + 1);
        end
      end
    end
    dq.delete();
    for (int k = 0; k < 5; k++) send(1'b1, 4'sd5, 4'sd5, 1'b0, k == 0, k == 4);
    @(negedge clk);
    rst = 1'b1; vld = 1'b0; sop = 1'b0; eop = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({acc_i, acc_q, acc_vld, acc_ovf, resync, epoch} !== '0) begin
      n_fail++; $display("FAIL midreset_outputs: got i=%0d q=%0d vld=%b ep=%0d, want all 0",
                         acc_i, acc_q, acc_vld, epoch);
    end
    rst = 1'b0;
    idle(6);
    n_tests++;
    if (dq.size() != 0 || epoch !== 16'd0) begin
      n_fail++; $display("FAIL midreset_nodump: got %0d dumps ep=%0d, want 0 0", dq.size(), epoch);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boc_wipe();
    test_saturation();
    test_resync();
    test_idle_eop();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/boc_corr_accum.md
Name: boc_corr_accum

Overview:
Correlator accumulate-and-dump that consumes the local BOC code stream and its period markers from the local code generator. Each cycle it wipes the code off the incoming baseband I/Q samples, integrating over one PRN code period bounded by the sop and eop strobes. At each period end it dumps one I/Q correlation result to the tracking loop.
One instance per correlator arm: early, prompt or late.

Parameters:
SAMPLE_WIDTH, 4, signed two's-complement width of rx_sample_i/q
ACC_WIDTH, 20, signed width of accumulators and dump outputs
CNT_WIDTH, 16, width of the epoch counter and of the optional sample counter

Ports:
rx_clk  input  1  system clock
rx_rst  input  1  synchronous active-high reset
rx_sample_i  input  SAMPLE_WIDTH  baseband in-phase sample, signed
rx_sample_q  input  SAMPLE_WIDTH  baseband quadrature sample, signed
rx_sample_vld  input  1  sample valid; all rx_* code inputs qualified by it
rx_loc_boc  input  1  local BOC chip; 0 maps to +1, 1 maps to -1
rx_prn_sop  input  1  current sample is the first of a code period
rx_prn_eop  input  1  current sample is the last of a code period
tx_acc_i  output  ACC_WIDTH  dumped I correlation, signed, held between dumps
tx_acc_q  output  ACC_WIDTH  dumped Q correlation, signed, held between dumps
tx_acc_vld  output  1  one-cycle dump strobe
tx_acc_ovf  output  1  saturation occurred in the dumped period; valid with tx_acc_vld, held with the data
tx_resync  output  1  one-cycle pulse: sop seen mid-period, partial sum discarded
tx_epoch_cnt  output  CNT_WIDTH  number of completed dumps, wraps modulo 2^CNT_WIDTH

Behaviour:
- Reset values: all outputs 0; internal state IDLE; accumulators 0; pipeline valids 0. Reset mid-period discards the partial sum and suppresses any pending dump.
- Stage 1, registered wipe-off, only when rx_sample_vld=1:
  - prod_i/q = rx_loc_boc ? -sample : +sample.
  - Negation is sign-extended to SAMPLE_WIDTH+1 bits, so -(-8)=+8 is exact.
  - sop, eop and valid are registered alongside the products.
- Stage 2 accumulate, state machine:
  - IDLE: stage-1 samples are ignored until stage-1 sop=1. Then acc = prod, ovf = 0, and the state goes to ACCUM. If eop=1 in the same sample, the sample is also dumped (single-sample period) and the state stays IDLE.
  - ACCUM, plain sample: acc = sat(acc + prod).
  - ACCUM, eop=1 and sop=0: dump sat(acc + prod), then go to IDLE.
  - ACCUM, sop=1 and eop=0: tx_resync=1; acc = prod (partial discarded); ovf cleared; stay in ACCUM.
  - ACCUM, sop=1 and eop=1: tx_resync=1, dump prod alone, go to IDLE.
  - Eop while in IDLE, without sop, is ignored. No dump is produced.
- Saturation:
  - Sum computed at ACC_WIDTH+1 bits, clamped to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
  - Any clamp sets the period's ovf; ovf is sticky until the next period start.
  - I and Q share one ovf flag.
- Dump:
  - tx_acc_vld goes high for exactly one cycle, 2 cycles after the rx_clk edge that samples the eop input: eop sampled at edge N, tx_acc_vld high after edge N+2.
  - tx_acc_i/q/ovf update in the same cycle and hold until the next dump.
  - tx_epoch_cnt increments in the same cycle.
- Invalid cycles: with rx_sample_vld=0, code inputs are don't-care and the accumulators hold.
- Throughput: one sample per clock. Back-to-back periods (eop followed by sop on the next valid sample) lose no sample.

Optional Feature:
Macro BOC_CORR_SAMPLE_CNT_EN.
- Defined: adds output port tx_samp_cnt, CNT_WIDTH wide, reset 0.
  - Carries the number of valid samples integrated into the dumped period, including the sop and eop samples.
  - Updates with tx_acc_vld and saturates at all-ones.
  - It is cleared by resync, together with the accumulator.
- Not defined: the port and its counter are absent. All other behaviour is identical.

Test Plan:
- Reset then sop, 9 valid samples, eop on the 10th; I=+3 every sample, loc_boc=0 -> tx_acc_i=30, Q as driven, vld 2 cycles after the eop edge, epoch_cnt=1.
- Same stream with loc_boc alternating 0,1, I=+3 -> tx_acc_i=0. With all loc_boc=1 and I=-8 -> tx_acc_i=+80, no ovf.
- ACC_WIDTH=8, I=+7 for 20 samples, loc_boc=0 -> tx_acc_i=127, tx_acc_ovf=1. The next period, I=+1 for 5 samples -> 5, ovf=0.
- Sop, 4 samples, then sop again, then 3 samples with eop on the last (all I=+2) -> tx_resync pulse. Dump tx_acc_i=8, covering 4 samples from the second sop onward; with BOC_CORR_SAMPLE_CNT_EN, tx_samp_cnt=4.
- Eop with no preceding sop after reset -> no vld, epoch_cnt=0. Then sop+eop on one sample with I=-5 and loc_boc=0 -> tx_acc_i=-5, vld.
- Periods back-to-back for 3 epochs with rx_sample_vld toggled randomly -> each dump equals the model sum, epoch_cnt 1,2,3. Assert rx_rst mid-period 2 -> no dump, all outputs 0.
